rw_strobe_ctrl: RTL and testbench
=================================

RW_STROBE_CTRL -- requirements
Module: rw_strobe_ctrl

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning number of strobe channels (1..16).
REQ-002 The block SHALL have parameter CH_W, default 2, meaning channel-select width; the condition 2**CH_W >= NCH SHALL hold.
REQ-003 The block SHALL have parameter WAIT_W, default 3, meaning wait-state count width.
REQ-004 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of dev_wait stretch cycles before abort (1..255).
REQ-005 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port req, input, 1 bit: transfer request, sampled only while ready=1.
REQ-008 The block SHALL have port op, input, 1 bit: 0=read, 1=write; captured with req.
REQ-009 The block SHALL have port ch, input, CH_W bits: target channel; captured with req.
REQ-010 The block SHALL have port wait_cycles, input, WAIT_W bits: extra strobe cycles W; captured with req.
REQ-011 The block SHALL have port dev_wait, input, 1 bit: device stretch request, sampled in STROBE only.
REQ-012 The block SHALL have port ready, output, 1 bit: idle and able to accept req.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port err, output, 1 bit: error qualifier, valid only when done=1.
REQ-015 The block SHALL have port notWR, output, NCH bits: active-low write strobes, one per channel.
REQ-016 The block SHALL have port notRD, output, NCH bits: active-low read strobes, one per channel.

Function
REQ-017 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-018 The FSM SHALL have states IDLE, SETUP, STROBE and HOLD, and SHALL assert ready=1 only in IDLE.
REQ-019 IDLE SHALL move to SETUP when req=1 is sampled at a rising edge, capturing op, ch and wait_cycles on that same edge; req=0 SHALL leave it in IDLE.
REQ-020 SETUP SHALL last exactly 1 cycle with all strobes high, then SHALL move to STROBE.
REQ-021 In STROBE, exactly one strobe bit SHALL be low: notWR[ch] if op=1, notRD[ch] if op=0; all other bits SHALL remain high.
REQ-022 STROBE SHALL last a minimum of W+1 cycles; W=0 SHALL give 1 cycle and W=2**WAIT_W-1 SHALL give 2**WAIT_W cycles, with no counter wrap.
REQ-023 After the minimum, STROBE SHALL continue while dev_wait=1, for at most TIMEOUT additional cycles; dev_wait during the minimum period SHALL be ignored.
REQ-024 STROBE SHALL exit to HOLD on the first edge after the minimum at which dev_wait=0, or after TIMEOUT stretch cycles with dev_wait still 1.
REQ-025 HOLD SHALL last 1 cycle with all strobes high, done=1 and err set, then SHALL move to IDLE.
REQ-026 err SHALL be 1 on timeout abort or when the captured ch >= NCH; otherwise err SHALL be 0.
REQ-027 A request with ch >= NCH SHALL still pass through SETUP/STROBE/HOLD with identical timing, but SHALL assert no strobe.
REQ-028 A notWR bit and a notRD bit SHALL never be low in the same cycle, and no two channels SHALL be low in the same cycle.
REQ-029 Latency with no stretch: req sampled at edge E gives strobe low from edge E+2, done high from edge E+3+W, and ready high from edge E+4+W.
REQ-030 Back-to-back operation: req held high SHALL be accepted on the edge at which ready=1, so strobe-high gap between transfers is at least 3 cycles (HOLD, IDLE, SETUP).
REQ-031 Changes to op, ch and wait_cycles after capture SHALL have no effect on the transfer in progress.

Reset
REQ-032 On a rising edge with reset=1, the block SHALL enter IDLE with ready=1, done=0, err=0, notWR and notRD all ones, and counters cleared, from any state.
REQ-033 Reset SHALL take priority over req sampled on the same edge; that request SHALL be dropped.
REQ-034 After reset deasserts, the first req SHALL be accepted on the first edge with reset=0 and req=1.

Verification
REQ-035 Bench scenario: NCH=4, req write ch=2 W=0, dev_wait=0 -> notWR=4'b1011 for exactly 1 cycle, done pulse 1 cycle later with err=0, and notRD=4'hF throughout.
REQ-036 Bench scenario: read ch=1 W=7 -> notRD=4'b1101 for 8 cycles, then done=1 with err=0 and ready=1 on the following cycle.
REQ-037 Bench scenario: read ch=0 W=1, dev_wait=1 for 3 cycles after the minimum -> strobe low for 5 cycles, then err=0.
REQ-038 Bench scenario: dev_wait stuck at 1 with TIMEOUT=15, W=0 -> strobe low for 16 cycles, then done=1 with err=1.
REQ-039 Bench scenario: NCH=3, write ch=3 -> no strobe asserted, done after W+3 cycles with err=1.
REQ-040 Bench scenario: reset=1 asserted mid-STROBE -> all strobes high and ready=1 after that edge, no done pulse, and a new req accepted afterward with normal timing.

Source files
------------

// File: rtl/rw_strobe_ctrl_if.sv
// Request/strobe bus between a transfer initiator and rw_strobe_ctrl.
// The master drives requests and the device stretch line; the slave returns status and strobes.
interface rw_strobe_ctrl_if #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned WAIT_W = 3
);
    logic              req;
    logic              op;
    logic [CH_W-1:0]   ch;
    logic [WAIT_W-1:0] wait_cycles;
    logic              dev_wait;
    logic              ready;
    logic              done;
    logic              err;
    logic [NCH-1:0]    notWR;
    logic [NCH-1:0]    notRD;

    modport master (
        output req, op, ch, wait_cycles, dev_wait,
        input  ready, done, err, notWR, notRD
    );

    modport slave (
        input  req, op, ch, wait_cycles, dev_wait,
        output ready, done, err, notWR, notRD
    );
endinterface

// File: rtl/rw_strobe_ctrl.sv
// Read/write strobe sequencer: SETUP, a stretchable STROBE on one channel, then a HOLD cycle
// that reports completion. Every output is a register fed from the current FSM state.
module rw_strobe_ctrl #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned WAIT_W  = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset,
    rw_strobe_ctrl_if.slave bus
);
    localparam int unsigned STR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            state;
    state_t            nextState;
    logic              accept;
    logic              capOp;
    logic [CH_W-1:0]   capCh;
    logic [WAIT_W-1:0] waitCnt;
    logic [STR_W-1:0]  stretchCnt;
    logic              timedOut;
    logic              chBad;

    logic              readyQ, readyD;
    logic              doneQ, doneD;
    logic              errQ, errD;
    logic [NCH-1:0]    notWRQ, notWRD;
    logic [NCH-1:0]    notRDQ, notRDD;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; STROBE only looks at dev_wait once the minimum count has expired
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req && readyQ) begin
                    accept    = 1'b1;
                    nextState = SETUP;
                end
            end
            SETUP:  nextState = STROBE;
            STROBE: begin
                if (waitCnt == '0 && (!bus.dev_wait || stretchCnt == STR_W'(TIMEOUT))) begin
                    nextState = HOLD;
                end
            end
            HOLD:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output decode; ready drops on the accepting edge so it never advertises a busy FSM
    always_comb begin
        chBad  = (32'(capCh) >= NCH);
        readyD = (state == IDLE) && (nextState == IDLE);
        doneD  = (state == HOLD);
        errD   = (state == HOLD) && (timedOut || chBad);
        notWRD = '1;
        notRDD = '1;
        if (state == STROBE && !chBad) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (32'(capCh) == i) begin
                    if (capOp) begin
                        notWRD[i] = 1'b0;
                    end else begin
                        notRDD[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Captured request, wait/stretch counters and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            capOp      <= 1'b0;
            capCh      <= '0;
            waitCnt    <= '0;
            stretchCnt <= '0;
            timedOut   <= 1'b0;
            readyQ     <= 1'b1;
            doneQ      <= 1'b0;
            errQ       <= 1'b0;
            notWRQ     <= '1;
            notRDQ     <= '1;
        end else begin
            readyQ <= readyD;
            doneQ  <= doneD;
            errQ   <= errD;
            notWRQ <= notWRD;
            notRDQ <= notRDD;
            if (accept) begin
                capOp      <= bus.op;
                capCh      <= bus.ch;
                waitCnt    <= bus.wait_cycles;
                stretchCnt <= '0;
                timedOut   <= 1'b0;
            end else if (state == STROBE) begin
                if (waitCnt != '0) begin
                    waitCnt <= waitCnt - WAIT_W'(1);
                end else if (bus.dev_wait) begin
                    if (stretchCnt == STR_W'(TIMEOUT)) begin
                        timedOut <= 1'b1;
                    end else begin
                        stretchCnt <= stretchCnt + STR_W'(1);
                    end
                end
            end
        end
    end

    assign bus.ready = readyQ;
    assign bus.done  = doneQ;
    assign bus.err   = errQ;
    assign bus.notWR = notWRQ;
    assign bus.notRD = notRDQ;
endmodule

// File: tb/tb_rw_strobe_ctrl.sv
// Bench for rw_strobe_ctrl: a 4-channel and a 3-channel instance share one stimulus stream and
// are checked cycle by cycle against a transaction-level timing model.
module tb_rw_strobe_ctrl;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned WAIT_W  = 3;
    localparam int unsigned TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req = 1'b0;
    logic              op = 1'b0;
    logic              devWait = 1'b0;
    logic [CH_W-1:0]   ch = '0;
    logic [WAIT_W-1:0] waitCycles = '0;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clock = ~clock;

    rw_strobe_ctrl_if #(.NCH(4), .CH_W(CH_W), .WAIT_W(WAIT_W)) busA ();
    rw_strobe_ctrl_if #(.NCH(3), .CH_W(CH_W), .WAIT_W(WAIT_W)) busB ();

    assign busA.req = req;
    assign busA.op = op;
    assign busA.ch = ch;
    assign busA.wait_cycles = waitCycles;
    assign busA.dev_wait = devWait;
    assign busB.req = req;
    assign busB.op = op;
    assign busB.ch = ch;
    assign busB.wait_cycles = waitCycles;
    assign busB.dev_wait = devWait;

    rw_strobe_ctrl #(.NCH(4), .CH_W(CH_W), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) dutA (
        .clock(clock), .reset(reset), .bus(busA));
    rw_strobe_ctrl #(.NCH(3), .CH_W(CH_W), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) dutB (
        .clock(clock), .reset(reset), .bus(busB));

    typedef struct {
        logic o;
        int   c;
        int   w;
        int   ones;
        int   expLen;
        logic expErrA;
        logic expErrB;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(logic r, logic d, logic [7:0] wrLow, logic [7:0] rdLow);
        return {14'b0, r, d, wrLow, rdLow};
    endfunction

    function automatic logic [31:0] actA();
        return pack(busA.ready, busA.done, {4'b0, ~busA.notWR}, {4'b0, ~busA.notRD});
    endfunction

    function automatic logic [31:0] actB();
        return pack(busB.ready, busB.done, {5'b0, ~busB.notWR}, {5'b0, ~busB.notRD});
    endfunction

    // Expected outputs k cycles after the accepting edge, for a strobe that lasts len cycles
    function automatic logic [31:0] expOuts(int nch, int k, int len, logic o, int c);
        logic [7:0] wr;
        logic [7:0] rd;
        wr = '0;
        rd = '0;
        if (k >= 2 && k <= len + 1 && c < nch) begin
            if (o) wr[c] = 1'b1;
            else   rd[c] = 1'b1;
        end
        return pack(k >= len + 3, k == len + 2, wr, rd);
    endfunction

    // One transfer; ones = number of post-minimum edges with dev_wait=1 (> TIMEOUT means stuck)
    task automatic runTxn(input logic o, input int c, input int w, input int ones,
                          output int lenSeen, output logic errSeenA, output logic errSeenB);
        int   len;
        int   d;
        int   guard;
        logic tmo;
        tmo      = (ones > int'(TIMEOUT));
        len      = w + 1 + (tmo ? int'(TIMEOUT) : ones);
        lenSeen  = 0;
        errSeenA = 1'b0;
        errSeenB = 1'b0;
        guard    = 0;
        while (!busA.ready && guard < 50) begin
            req = 1'b0;
            @(posedge clock); #1;
            guard++;
        end
        check("ready_before_req", 32'(busA.ready), 32'd1);
        req        = 1'b1;
        op         = o;
        ch         = CH_W'(c);
        waitCycles = WAIT_W'(w);
        devWait    = 1'($urandom_range(0, 1));
        for (int k = 0; k <= len + 3; k++) begin
            if (k > 0) begin
                req        = 1'($urandom_range(0, 1));
                op         = 1'($urandom_range(0, 1));
                ch         = CH_W'($urandom_range(0, 3));
                waitCycles = WAIT_W'($urandom_range(0, 7));
                d          = k - (2 + w);
                if (d < 0)        devWait = 1'($urandom_range(0, 1));
                else if (tmo)     devWait = (d <= int'(TIMEOUT)) ? 1'b1 : 1'($urandom_range(0, 1));
                else if (d < ones) devWait = 1'b1;
                else if (d == ones) devWait = 1'b0;
                else              devWait = 1'($urandom_range(0, 1));
            end
            @(posedge clock); #1;
            check("cycleA", actA(), expOuts(4, k, len, o, c));
            check("cycleB", actB(), expOuts(3, k, len, o, c));
            if (k == len + 2) begin
                check("errA", 32'(busA.err), 32'(tmo));
                check("errB", 32'(busB.err), 32'(tmo || c >= 3));
            end
            if (busA.notWR != 4'hF || busA.notRD != 4'hF) lenSeen++;
            if (busA.done) errSeenA = busA.err;
            if (busB.done) errSeenB = busB.err;
        end
        req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lenSeen;
        logic eA;
        logic eB;
        int   o;
        int   c;
        int   w;
        int   ones;
        int   r;

        vecs[0] = '{1'b1, 2, 0, 0, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1, 7, 0, 8, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 0, 1, 3, 5, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 0, 0, 16, 16, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 3, 2, 0, 3, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 0, 7, 15, 23, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 3, 0, 2, 3, 1'b0, 1'b1};

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_A", actA(), pack(1'b1, 1'b0, 8'h0, 8'h0));
        check("reset_B", actB(), pack(1'b1, 1'b0, 8'h0, 8'h0));
        check("reset_err", {30'b0, busA.err, busB.err}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            runTxn(vecs[i].o, vecs[i].c, vecs[i].w, vecs[i].ones, lenSeen, eA, eB);
            check("vec_len", 32'(lenSeen), 32'(vecs[i].expLen));
            check("vec_errA", 32'(eA), 32'(vecs[i].expErrA));
            check("vec_errB", 32'(eB), 32'(vecs[i].expErrB));
        end

        // Reset in the middle of a strobe, with a request pending on the same edge
        req = 1'b1; op = 1'b1; ch = 2'd1; waitCycles = 3'd5; devWait = 1'b0;
        @(posedge clock); #1;
        req = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        check("mid_strobe_A", actA(), pack(1'b0, 1'b0, 8'h02, 8'h00));
        reset = 1'b1;
        req   = 1'b1;
        @(posedge clock); #1;
        check("rst_strobe_A", actA(), pack(1'b1, 1'b0, 8'h0, 8'h0));
        check("rst_strobe_B", actB(), pack(1'b1, 1'b0, 8'h0, 8'h0));
        check("rst_strobe_err", {30'b0, busA.err, busB.err}, 32'd0);
        reset = 1'b0;
        req   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            check("rst_quiet_A", actA(), pack(1'b1, 1'b0, 8'h0, 8'h0));
        end
        runTxn(1'b1, 1, 2, 0, lenSeen, eA, eB);
        check("post_rst_len", 32'(lenSeen), 32'd3);

        for (int n = 0; n < 40; n++) begin
            o = int'($urandom_range(0, 1));
            c = int'($urandom_range(0, 3));
            w = int'($urandom_range(0, 7));
            r = int'($urandom_range(0, 9));
            if (r < 4)       ones = 0;
            else if (r < 8)  ones = int'($urandom_range(1, 5));
            else if (r == 8) ones = int'(TIMEOUT);
            else             ones = int'(TIMEOUT) + 1;
            runTxn(1'(o), c, w, ones, lenSeen, eA, eB);
            check("rand_len", 32'(lenSeen), 32'(w + 1 + (ones > int'(TIMEOUT) ? int'(TIMEOUT) : ones)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
